// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I controller:
// state enum, opcodes, datapath mux selects and ALU operations.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALR2    = 4'd12,
    S_LUI      = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  // Which ALU operation the current state asks for; FUNCT defers to funct3/funct7.
  typedef enum logic [1:0] {
    AC_ADD   = 2'd0,
    AC_SUB   = 2'd1,
    AC_FUNCT = 2'd2
  } alu_class_t;

  localparam logic [6:0] OP_LUI   = 7'd55;
  localparam logic [6:0] OP_IMM   = 7'd19;
  localparam logic [6:0] OP_BR    = 7'd99;
  localparam logic [6:0] OP_LOAD  = 7'd3;
  localparam logic [6:0] OP_STORE = 7'd35;
  localparam logic [6:0] OP_JALR  = 7'd103;
  localparam logic [6:0] OP_JAL   = 7'd111;
  localparam logic [6:0] OP_R     = 7'd51;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] IMM_NONE   = 2'b00;
  localparam logic [1:0] IMM_EXT    = 2'b01;

  // funct3/funct7 legality for the opcodes that carry them; lui/jal have none.
  function automatic logic funct_legal(logic [6:0] op, logic [2:0] f3, logic [6:0] f7);
    logic ok;
    ok = 1'b1;
    case (op)
      OP_IMM, OP_JALR:   ok = (f3 == 3'b000);
      OP_LOAD, OP_STORE: ok = (f3 == 3'b010);
      OP_BR:             ok = (f3 == 3'b000) || (f3 == 3'b001);
      OP_R:              ok = (f3 == 3'b000) && ((f7 == 7'h00) || (f7 == 7'h20));
      default:           ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the state's ALU class plus funct3/funct7[5] onto the ALUControl code.
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  alu_class_t  alu_class_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7b5_i,
  output logic [2:0]  alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_class_i)
      AC_SUB:   alu_control_o = ALU_SUB;
      AC_FUNCT: alu_control_o = ((funct3_i == 3'b000) && funct7b5_i) ? ALU_SUB : ALU_ADD;
      default:  alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main controller FSM of the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback, and traps on anything unsupported.
module multicycle_control
  import rv_ctrl_pkg::*;
#(
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] instr,
  input  logic               Zero,
  input  logic               mem_rdy,
  output logic               MemReq,
  output logic               MemWrite,
  output logic               AdrSrc,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               RegWrite,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ImmSrc,
  output logic               illegal,
  output logic [3:0]         state_o
);

  state_t     state_q, state_d;
  alu_class_t alu_class;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign funct7            = instr[31:25];
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};
  assign state_o           = state_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        if (!funct_legal(opcode, funct3, funct7)) state_d = S_TRAP;
        else begin
          case (opcode)
            OP_LOAD, OP_STORE: state_d = S_MEMADR;
            OP_R:              state_d = S_EXECR;
            OP_IMM:            state_d = S_EXECI;
            OP_BR:             state_d = S_BRANCH;
            OP_JAL:            state_d = S_JAL;
            OP_JALR:           state_d = S_JALR;
            OP_LUI:            state_d = S_LUI;
            default:           state_d = S_TRAP;
          endcase
        end
      end
      S_MEMADR:   state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_rdy) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR:     state_d = S_JALR2;
      S_JALR2:    state_d = S_ALUWB;
      S_LUI:      state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
  end

  always_comb begin
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    alu_class = AC_ADD;
    ResultSrc = RES_ALUOUT;
    ImmSrc    = IMM_NONE;
    illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemReq = 1'b1; ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALURES;
        IRWrite = mem_rdy; PCWrite = mem_rdy;
      end
      S_DECODE:   begin ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_IMM; ImmSrc = IMM_EXT; end
      S_MEMADR:   begin ALUSrcA = SRCA_RD1; ALUSrcB = SRCB_IMM; ImmSrc = IMM_EXT; end
      S_MEMREAD:  begin MemReq = 1'b1; AdrSrc = 1'b1; end
      S_MEMWB:    begin ResultSrc = RES_RDATA; RegWrite = 1'b1; end
      S_MEMWRITE: begin MemReq = 1'b1; MemWrite = 1'b1; AdrSrc = 1'b1; end
      S_EXECR:    begin ALUSrcA = SRCA_RD1; alu_class = AC_FUNCT; end
      S_EXECI:    begin ALUSrcA = SRCA_RD1; ALUSrcB = SRCB_IMM; ImmSrc = IMM_EXT; end
      S_ALUWB:    RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = SRCA_RD1; alu_class = AC_SUB;
        PCWrite = (funct3 == 3'b000) ? Zero : ~Zero;
      end
      S_JAL, S_JALR2: begin ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_FOUR; PCWrite = 1'b1; end
      S_JALR:     begin ALUSrcA = SRCA_RD1; ALUSrcB = SRCB_IMM; ImmSrc = IMM_EXT; end
      S_LUI:      begin ImmSrc = IMM_EXT; ResultSrc = RES_IMM; RegWrite = 1'b1; end
      S_TRAP:     illegal = 1'b1;
      default:    illegal = 1'b1;
    endcase
    // Reset wins immediately, even mid-wait, so no stray strobe leaks out.
    if (rst) begin
      MemReq = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0;
      PCWrite = 1'b0; RegWrite = 1'b0; illegal = 1'b0;
    end
  end

  alu_decoder u_alu_decoder (
    .alu_class_i   (alu_class),
    .funct3_i      (funct3),
    .funct7b5_i    (funct7[5]),
    .alu_control_o (ALUControl)
  );

endmodule
